// File: rtl/fp_addsub_param_if.sv
// Request/response bundle between the calculator control FSM and the FP add/sub unit.
interface fp_addsub_param_if #(
  parameter int EW = 8,
  parameter int MW = 23
);
  logic             start;
  logic             op;
  logic [EW+MW:0]   x;
  logic [EW+MW:0]   y;
  logic             busy;
  logic             done;
  logic [EW+MW:0]   result;
  logic [3:0]       flags;

  modport master (output start, op, x, y, input busy, done, result, flags);
  modport slave  (input start, op, x, y, output busy, done, result, flags);
endinterface

// File: rtl/fp_addsub_param.sv
// Multi-cycle parametrised FP adder/subtractor: FTZ, RNE rounding, special values,
// status flags {invalid, overflow, underflow, inexact} and a busy/done handshake.
module fp_addsub_param #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  fp_addsub_param_if.slave  bus
);
  localparam int FW = 1 + EW + MW;
  localparam int W  = MW + 4;  // {hidden, mant, G, R, S}; bit W is the carry
  localparam logic [EW-1:0] EMAX     = {EW{1'b1}};
  localparam logic [EW:0]   E_ONE    = (EW+1)'(1);
  localparam logic [EW:0]   COLLAPSE = (EW+1)'(MW + 3);

  typedef struct packed {
    logic          s;
    logic [EW-1:0] e;
    logic [MW-1:0] f;
  } fp_t;

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;

  state_t state, nxt;

  logic          sgn, sub;
  logic [EW:0]   ea, eb;
  logic [W:0]    ma, mb;
  logic [FW-1:0] res_q;
  logic [3:0]    flg_q;

  // operand decode, with y already carrying the effective sign
  fp_t fx, fy, fa, fb;
  logic x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, special, x_ge;

  assign fx = bus.x;
  assign fy = {bus.y[FW-1] ^ bus.op, bus.y[FW-2:0]};

  assign x_nan   = (fx.e == EMAX) && (fx.f != '0);
  assign y_nan   = (fy.e == EMAX) && (fy.f != '0);
  assign x_inf   = (fx.e == EMAX) && (fx.f == '0);
  assign y_inf   = (fy.e == EMAX) && (fy.f == '0);
  assign x_zero  = (fx.e == '0);
  assign y_zero  = (fy.e == '0);
  assign special = x_nan | y_nan | x_inf | y_inf | x_zero | y_zero;

  assign x_ge = {fx.e, fx.f} >= {fy.e, fy.f};
  assign fa   = x_ge ? fx : fy;
  assign fb   = x_ge ? fy : fx;

  logic [FW-1:0] qnan, spec_res;
  logic [3:0]    spec_flg;

  assign qnan = {1'b0, EMAX, 1'b1, {(MW-1){1'b0}}};

  always_comb begin
    spec_res = '0;
    spec_flg = '0;
    if (x_nan || y_nan) begin
      spec_res = qnan;
    end else if (x_inf && y_inf) begin
      if (fx.s != fy.s) begin
        spec_res = qnan;
        spec_flg = 4'b1000;
      end else begin
        spec_res = {fx.s, EMAX, {MW{1'b0}}};
      end
    end else if (x_inf) begin
      spec_res = {fx.s, EMAX, {MW{1'b0}}};
    end else if (y_inf) begin
      spec_res = {fy.s, EMAX, {MW{1'b0}}};
    end else if (x_zero && y_zero) begin
      spec_res = {fx.s & fy.s, {(FW-1){1'b0}}};
    end else if (x_zero) begin
      spec_res = fy;
    end else begin
      spec_res = fx;
    end
  end

  // datapath helpers
  logic [EW:0] diff, eb_inc, e_dec, er;
  logic        collapse;
  logic [W:0]  sum, norm_sh;

  assign diff     = ea - eb;
  assign collapse = diff > COLLAPSE;
  assign eb_inc   = eb + E_ONE;
  assign e_dec    = ea - E_ONE;
  assign sum      = sub ? (ma - mb) : (ma + mb);
  assign norm_sh  = {ma[W-1:0], 1'b0};

  // RNE on the stored fraction; hidden bit is 1 whenever the result is not flushed,
  // so a fraction carry-out is the mantissa carry-out
  logic          g, r, s, lsb, inc, inexact;
  logic [MW:0]   fr;
  logic [FW-1:0] rnd_res;
  logic [3:0]    rnd_flg;

  assign lsb     = ma[3];
  assign g       = ma[2];
  assign r       = ma[1];
  assign s       = ma[0];
  assign inc     = g & (r | s | lsb);
  assign inexact = g | r | s;
  assign fr      = {1'b0, ma[W-2:3]} + {{MW{1'b0}}, inc};
  assign er      = ea + {{EW{1'b0}}, fr[MW]};

  always_comb begin
    rnd_res = {sgn, er[EW-1:0], fr[MW-1:0]};
    rnd_flg = {3'b000, inexact};
    if (ea == '0) begin
      rnd_res = {sgn, {(FW-1){1'b0}}};
      rnd_flg = 4'b0011;
    end else if (er >= {1'b0, EMAX}) begin
      rnd_res = {sgn, EMAX, {MW{1'b0}}};
      rnd_flg = 4'b0101;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // next state
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (bus.start) nxt = special ? S_DONE : ((fa.e == fb.e) ? S_ADD : S_ALIGN);
      S_ALIGN: if (collapse || eb_inc == ea) nxt = S_ADD;
      S_ADD: begin
        if (sum == '0)                 nxt = S_DONE;
        else if (sum[W] || !sum[W-1])  nxt = S_NORM;
        else                           nxt = S_ROUND;
      end
      S_NORM:  if (ma[W] || norm_sh[W-1] || e_dec == '0) nxt = S_ROUND;
      S_ROUND: nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    bus.busy   = (state != S_IDLE);
    bus.done   = (state == S_DONE);
    bus.result = res_q;
    bus.flags  = flg_q;
  end

  // working datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn <= 1'b0;
      sub <= 1'b0;
      ea  <= '0;
      eb  <= '0;
      ma  <= '0;
      mb  <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (bus.start && !special) begin
          sgn <= fa.s;
          sub <= fa.s ^ fb.s;
          ea  <= {1'b0, fa.e};
          eb  <= {1'b0, fb.e};
          ma  <= {2'b01, fa.f, 3'b000};
          mb  <= {2'b01, fb.f, 3'b000};
        end
        S_ALIGN: begin
          if (collapse) begin
            // B is entirely below the sticky position: only its presence matters
            mb <= {{W{1'b0}}, 1'b1};
            eb <= ea;
          end else begin
            mb <= {1'b0, mb[W:2], mb[1] | mb[0]};
            eb <= eb_inc;
          end
        end
        S_ADD: ma <= sum;
        S_NORM: begin
          if (ma[W]) begin
            ma <= {1'b0, ma[W:2], ma[1] | ma[0]};
            ea <= ea + E_ONE;
          end else begin
            ma <= norm_sh;
            ea <= e_dec;
          end
        end
        default: ;
      endcase
    end
  end

  // result/flags only change on the way into DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      flg_q <= '0;
    end else if (state == S_IDLE && bus.start && special) begin
      res_q <= spec_res;
      flg_q <= spec_flg;
    end else if (state == S_ADD && sum == '0) begin
      res_q <= '0;
      flg_q <= '0;
    end else if (state == S_ROUND) begin
      res_q <= rnd_res;
      flg_q <= rnd_flg;
    end
  end
endmodule
